// File: rtl/cpu_sequencer_pkg.sv
// Shared types and encodings for the MSP430 control sequencer: FSM states,
// address-source codes, opcode constants and the decoded-instruction record.
package cpu_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_RESET_VEC  = 4'd0,
    ST_FETCH      = 4'd1,
    ST_SRC_IDX    = 4'd2,
    ST_SRC_RD     = 4'd3,
    ST_DST_IDX    = 4'd4,
    ST_DST_RD     = 4'd5,
    ST_EXEC       = 4'd6,
    ST_WB_MEM     = 4'd7,
    ST_PUSH_DEC   = 4'd8,
    ST_PUSH_WR    = 4'd9,
    ST_POP_RD     = 4'd10,
    ST_INT_PC_DEC = 4'd11,
    ST_INT_PC_WR  = 4'd12,
    ST_INT_SR_DEC = 4'd13,
    ST_INT_SR_WR  = 4'd14,
    ST_INT_VEC    = 4'd15
  } state_t;

  localparam logic [2:0] MAB_PC  = 3'd0;
  localparam logic [2:0] MAB_SRC = 3'd1;
  localparam logic [2:0] MAB_DST = 3'd2;
  localparam logic [2:0] MAB_SP  = 3'd3;
  localparam logic [2:0] MAB_VEC = 3'd4;

  localparam logic [1:0] AS_REG = 2'b00;
  localparam logic [1:0] AS_IDX = 2'b01;
  localparam logic [1:0] AS_IND = 2'b10;
  localparam logic [1:0] AS_INC = 2'b11;

  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h9;
  localparam logic [3:0] OP_BIT = 4'hB;

  localparam logic [2:0] OP2_RRC  = 3'd0;
  localparam logic [2:0] OP2_SWPB = 3'd1;
  localparam logic [2:0] OP2_RRA  = 3'd2;
  localparam logic [2:0] OP2_SXT  = 3'd3;
  localparam logic [2:0] OP2_PUSH = 3'd4;
  localparam logic [2:0] OP2_CALL = 3'd5;
  localparam logic [2:0] OP2_RETI = 3'd6;

  localparam logic [3:0] REG_SR  = 4'd2;
  localparam logic [3:0] REG_CG2 = 4'd3;

  typedef enum logic [1:0] {FMT_ILLEGAL, FMT_JUMP, FMT_I, FMT_II} fmt_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_IDX, SRC_IND, SRC_INC} src_mode_t;

  typedef struct packed {
    fmt_t      fmt;
    src_mode_t src_mode;
    logic      dst_mem;   // result lives in memory (Ad=1, or Format II memory operand)
    logic      is_mov;
    logic      is_push;
    logic      is_call;
    logic      is_reti;
    logic      alu;       // instruction needs the ALU in EXEC
    logic      wb;        // instruction writes a result back
  } dec_t;

endpackage

// File: rtl/cpu_sequencer_decode.sv
// Combinational instruction decoder: classifies an MSP430 instruction word
// into format, opcode class and operand addressing mode.
module cpu_sequencer_decode
  import cpu_sequencer_pkg::*;
(
  input  logic [15:0] iw,
  output dec_t        dec
);

  logic [3:0] op_reg;
  logic [1:0] as_mode;
  logic       legal;
  logic       cg;

  always_comb begin
    dec     = '0;
    op_reg  = iw[3:0];
    as_mode = iw[5:4];
    legal   = 1'b0;
    cg      = 1'b0;

    if (iw[15:13] == 3'b001) begin
      dec.fmt = FMT_JUMP;
    end else if (iw[15:12] >= 4'h4) begin
      op_reg      = iw[11:8];
      dec.fmt     = FMT_I;
      dec.dst_mem = iw[7];
      dec.is_mov  = (iw[15:12] == OP_MOV);
      dec.alu     = (iw[15:12] != OP_MOV);
      dec.wb      = (iw[15:12] != OP_CMP) && (iw[15:12] != OP_BIT);
    end else if (iw[15:10] == 6'b000100) begin
      // Byte forms of SWPB, SXT, CALL and RETI do not exist and decode as illegal.
      case (iw[9:7])
        OP2_RRC, OP2_RRA: begin
          legal   = 1'b1;
          dec.alu = 1'b1;
          dec.wb  = 1'b1;
        end
        OP2_SWPB, OP2_SXT: begin
          legal   = !iw[6];
          dec.alu = 1'b1;
          dec.wb  = 1'b1;
        end
        OP2_PUSH: begin
          legal       = 1'b1;
          dec.is_push = 1'b1;
        end
        OP2_CALL: begin
          legal       = !iw[6];
          dec.is_call = 1'b1;
        end
        OP2_RETI: begin
          legal       = !iw[6];
          dec.is_reti = 1'b1;
        end
        default: legal = 1'b0;
      endcase
      if (legal) dec.fmt = FMT_II;
    end

    // R3 in any mode and R2 in modes 10/11 are constant generators: no memory access.
    cg = (op_reg == REG_CG2) || ((op_reg == REG_SR) && as_mode[1]);
    if ((dec.fmt inside {FMT_I, FMT_II}) && !dec.is_reti && !cg) begin
      case (as_mode)
        AS_REG: dec.src_mode = SRC_NONE;
        AS_IDX: dec.src_mode = SRC_IDX;
        AS_IND: dec.src_mode = SRC_IND;
        AS_INC: dec.src_mode = SRC_INC;
      endcase
    end
    if (dec.fmt == FMT_II) dec.dst_mem = (dec.src_mode != SRC_NONE);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// MSP430 control sequencer: fetch/decode, operand and stack access sequencing,
// interrupt/reset vectoring, and the per-cycle register-file strobes.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFE,
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mdb_in,
  input  logic        mem_rdy,
  input  logic        GIE,
  input  logic        irq,
  input  logic [15:0] irq_vec,
  input  logic        nmi,
  output logic        IF,
  output logic        IdxF,
  output logic        SPF,
  output logic        INTACK,
  output logic        Ex,
  output logic        RW,
  output logic        srcInc,
  output logic        dstInc,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  mab_sel,
  output logic [15:0] vec_addr,
  output logic [15:0] IW,
  output logic        irq_ack,
  output logic [3:0]  dbg_state
);

  // Memory handshake: a state that raises mem_rd or mem_wr holds that request and
  // mab_sel until the cycle mem_rdy=1; its strobes fire and the state advances
  // only in that cycle. States without a memory request last exactly one cycle.

  state_t state;
  logic   pop_second;
  logic   int_nmi;
  logic   int_take;
  dec_t   dec_new;
  dec_t   dec_cur;

  cpu_sequencer_decode u_dec_new (.iw(mdb_in), .dec(dec_new));
  cpu_sequencer_decode u_dec_cur (.iw(IW),     .dec(dec_cur));

  assign int_take  = nmi | (irq & GIE);
  assign dbg_state = state;

  function automatic state_t after_src(input dec_t d);
    state_t s;
    s = ST_EXEC;
    if (d.fmt == FMT_I) begin
      s = d.dst_mem ? ST_DST_IDX : ST_EXEC;
    end else if (d.is_push || d.is_call) begin
      s = ST_PUSH_DEC;
    end else if (d.is_reti) begin
      s = ST_POP_RD;
    end
    return s;
  endfunction

  function automatic state_t first_state(input dec_t d);
    state_t s;
    case (d.fmt)
      FMT_JUMP:    s = ST_EXEC;
      FMT_ILLEGAL: s = ST_FETCH;
      default: begin
        case (d.src_mode)
          SRC_IDX:          s = ST_SRC_IDX;
          SRC_IND, SRC_INC: s = ST_SRC_RD;
          default:          s = after_src(d);
        endcase
      end
    endcase
    return s;
  endfunction

  logic rd_raw;
  logic wr_raw;
  logic go;

  always_comb begin
    rd_raw  = 1'b0;
    wr_raw  = 1'b0;
    mab_sel = MAB_PC;
    IF      = 1'b0;
    IdxF    = 1'b0;
    SPF     = 1'b0;
    INTACK  = 1'b0;
    Ex      = 1'b0;
    RW      = 1'b0;
    srcInc  = 1'b0;
    dstInc  = 1'b0;  // no destination addressing mode auto-increments
    irq_ack = 1'b0;
    go      = 1'b0;

    case (state)
      ST_RESET_VEC: begin
        rd_raw  = 1'b1;
        mab_sel = MAB_VEC;
        INTACK  = 1'b1;
      end
      ST_FETCH: begin
        if (!int_take) begin
          rd_raw = 1'b1;
          IF     = 1'b1;
        end
      end
      ST_SRC_IDX, ST_DST_IDX: begin
        rd_raw = 1'b1;
        IdxF   = 1'b1;
      end
      ST_SRC_RD: begin
        rd_raw  = 1'b1;
        mab_sel = MAB_SRC;
        srcInc  = (dec_cur.src_mode == SRC_INC);
      end
      ST_DST_RD: begin
        rd_raw  = 1'b1;
        mab_sel = MAB_DST;
      end
      ST_EXEC: begin
        Ex = dec_cur.alu;
        RW = (dec_cur.wb && !dec_cur.dst_mem) || dec_cur.is_call;
      end
      ST_WB_MEM: begin
        wr_raw  = 1'b1;
        mab_sel = MAB_DST;
      end
      ST_PUSH_DEC, ST_INT_PC_DEC, ST_INT_SR_DEC: SPF = 1'b1;
      ST_PUSH_WR, ST_INT_PC_WR, ST_INT_SR_WR: begin
        wr_raw  = 1'b1;
        mab_sel = MAB_SP;
      end
      ST_POP_RD: begin
        // Popped word lands in SR on the first pop, PC on the second.
        rd_raw  = 1'b1;
        mab_sel = MAB_SP;
        srcInc  = 1'b1;
        RW      = 1'b1;
      end
      ST_INT_VEC: begin
        rd_raw  = 1'b1;
        mab_sel = MAB_VEC;
        INTACK  = 1'b1;
        irq_ack = !int_nmi;
      end
      default: ;
    endcase

    go      = rst && (!(rd_raw || wr_raw) || mem_rdy);
    IF      = IF      & go;
    IdxF    = IdxF    & go;
    SPF     = SPF     & go;
    INTACK  = INTACK  & go;
    Ex      = Ex      & go;
    RW      = RW      & go;
    srcInc  = srcInc  & go;
    irq_ack = irq_ack & go;
    mem_rd  = rd_raw  & rst;
    mem_wr  = wr_raw  & rst;
    if (!rst) mab_sel = MAB_VEC;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RESET_VEC;
      IW         <= '0;
      vec_addr   <= RESET_VECTOR;
      int_nmi    <= 1'b0;
      pop_second <= 1'b0;
    end else begin
      case (state)
        ST_RESET_VEC: if (mem_rdy) state <= ST_FETCH;
        ST_FETCH: begin
          if (int_take) begin
            vec_addr <= nmi ? NMI_VECTOR : irq_vec;
            int_nmi  <= nmi;
            state    <= ST_INT_PC_DEC;
          end else if (mem_rdy) begin
            IW    <= mdb_in;
            state <= first_state(dec_new);
          end
        end
        ST_SRC_IDX: if (mem_rdy) state <= ST_SRC_RD;
        ST_SRC_RD:  if (mem_rdy) state <= after_src(dec_cur);
        ST_DST_IDX: if (mem_rdy) state <= dec_cur.is_mov ? ST_EXEC : ST_DST_RD;
        ST_DST_RD:  if (mem_rdy) state <= ST_EXEC;
        ST_EXEC:    state <= (dec_cur.wb && dec_cur.dst_mem) ? ST_WB_MEM : ST_FETCH;
        ST_WB_MEM:  if (mem_rdy) state <= ST_FETCH;
        ST_PUSH_DEC: state <= ST_PUSH_WR;
        ST_PUSH_WR: if (mem_rdy) state <= dec_cur.is_call ? ST_EXEC : ST_FETCH;
        ST_POP_RD: begin
          if (mem_rdy) begin
            pop_second <= !pop_second;
            if (pop_second) state <= ST_FETCH;
          end
        end
        ST_INT_PC_DEC: state <= ST_INT_PC_WR;
        ST_INT_PC_WR:  if (mem_rdy) state <= ST_INT_SR_DEC;
        ST_INT_SR_DEC: state <= ST_INT_SR_WR;
        ST_INT_SR_WR:  if (mem_rdy) state <= ST_INT_VEC;
        ST_INT_VEC:    if (mem_rdy) state <= ST_FETCH;
        default:       state <= ST_RESET_VEC;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: steps the sequencer one cycle at a time and
// compares strobes, address select and latched state against hand-computed values.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] mdb_in;
  logic        mem_rdy;
  logic        GIE;
  logic        irq;
  logic [15:0] irq_vec;
  logic        nmi;
  logic        IF, IdxF, SPF, INTACK, Ex, RW, srcInc, dstInc;
  logic        mem_rd, mem_wr, irq_ack;
  logic [2:0]  mab_sel;
  logic [15:0] vec_addr;
  logic [15:0] IW;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [10:0] B_NONE   = 11'h000;
  localparam logic [10:0] B_IF     = 11'h400;
  localparam logic [10:0] B_IDXF   = 11'h200;
  localparam logic [10:0] B_SPF    = 11'h100;
  localparam logic [10:0] B_INTACK = 11'h080;
  localparam logic [10:0] B_EX     = 11'h040;
  localparam logic [10:0] B_RW     = 11'h020;
  localparam logic [10:0] B_SRCINC = 11'h010;
  localparam logic [10:0] B_DSTINC = 11'h008;
  localparam logic [10:0] B_RD     = 11'h004;
  localparam logic [10:0] B_WR     = 11'h002;
  localparam logic [10:0] B_ACK    = 11'h001;

  logic [15:0] strb_now;
  assign strb_now = {5'b0, IF, IdxF, SPF, INTACK, Ex, RW, srcInc, dstInc, mem_rd, mem_wr, irq_ack};

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .mdb_in(mdb_in), .mem_rdy(mem_rdy), .GIE(GIE), .irq(irq),
    .irq_vec(irq_vec), .nmi(nmi), .IF(IF), .IdxF(IdxF), .SPF(SPF), .INTACK(INTACK),
    .Ex(Ex), .RW(RW), .srcInc(srcInc), .dstInc(dstInc), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mab_sel(mab_sel), .vec_addr(vec_addr), .IW(IW), .irq_ack(irq_ack), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive on the falling edge, sample 1ns later, state advances on the next rising edge.
  task automatic step(input string tag, input logic rdy, input logic [15:0] mdb,
                      input logic [2:0] intr, input logic [10:0] exp_strb, input logic [2:0] exp_mab);
    @(negedge clk);
    mem_rdy = rdy;
    mdb_in  = mdb;
    {GIE, irq, nmi} = intr;
    #1;
    chk({tag, ".strb"}, strb_now, {5'b0, exp_strb});
    chk({tag, ".mab"}, {13'b0, mab_sel}, {13'b0, exp_mab});
  endtask

  task automatic chk_state(input string tag, input state_t s);
    chk({tag, ".state"}, {12'b0, dbg_state}, {12'b0, s});
  endtask

  initial begin
    rst = 1'b0; mem_rdy = 1'b0; mdb_in = 16'h4400;
    GIE = 1'b0; irq = 1'b0; nmi = 1'b0; irq_vec = 16'hFFF2;

    repeat (2) @(negedge clk);
    #1;
    chk("rst.strb", strb_now, 16'h0000);
    chk("rst.mab", {13'b0, mab_sel}, 16'd4);
    chk("rst.iw", IW, 16'h0000);
    chk("rst.vec", vec_addr, 16'hFFFE);
    chk_state("rst", ST_RESET_VEC);
    rst = 1'b1;

    // reset vector fetch, with one stalled cycle first
    step("rv_stall", 1'b0, 16'h4400, 3'b000, B_RD, 3'd4);
    step("rv",       1'b1, 16'h4400, 3'b000, B_RD | B_INTACK, 3'd4);

    // ADD R4,R5: FETCH then EXEC
    step("f_add",  1'b1, 16'h5405, 3'b000, B_IF | B_RD, 3'd0);
    step("ex_add", 1'b1, 16'h0000, 3'b000, B_EX | B_RW, 3'd0);
    chk("add.iw", IW, 16'h5405);

    // MOV #imm,&abs with a 3-cycle fetch stall and a stalled write-back
    for (int i = 0; i < 3; i++) begin
      step("f_stall", 1'b0, 16'h40B2, 3'b000, B_RD, 3'd0);
      chk_state("f_stall", ST_FETCH);
    end
    step("f_mov",    1'b1, 16'h40B2, 3'b000, B_IF | B_RD, 3'd0);
    step("src_imm",  1'b1, 16'h1234, 3'b000, B_RD | B_SRCINC, 3'd1);
    step("dst_idx",  1'b1, 16'h0200, 3'b000, B_RD | B_IDXF, 3'd0);
    step("ex_mov",   1'b1, 16'h0000, 3'b000, B_NONE, 3'd0);
    step("wb_stall", 1'b0, 16'h0000, 3'b000, B_WR, 3'd2);
    step("wb",       1'b1, 16'h0000, 3'b000, B_WR, 3'd2);

    // maskable interrupt; irq drops right after it is taken
    step("f_irq",    1'b1, 16'h5405, 3'b110, B_NONE, 3'd0);
    step("i_pc_dec", 1'b1, 16'h0000, 3'b000, B_SPF, 3'd0);
    chk("irq.vec", vec_addr, 16'hFFF2);
    step("i_pc_wr",  1'b1, 16'h0000, 3'b000, B_WR, 3'd3);
    step("i_sr_dec", 1'b1, 16'h0000, 3'b000, B_SPF, 3'd0);
    step("i_sr_wr",  1'b1, 16'h0000, 3'b000, B_WR, 3'd3);
    step("i_vec",    1'b1, 16'hC000, 3'b000, B_RD | B_INTACK | B_ACK, 3'd4);

    // nmi and irq together: nmi wins, no irq_ack
    step("f_nmi",     1'b1, 16'h5405, 3'b111, B_NONE, 3'd0);
    step("n_pc_dec",  1'b1, 16'h0000, 3'b000, B_SPF, 3'd0);
    chk("nmi.vec", vec_addr, 16'hFFFC);
    step("n_pc_wr",   1'b1, 16'h0000, 3'b000, B_WR, 3'd3);
    step("n_sr_dec",  1'b1, 16'h0000, 3'b000, B_SPF, 3'd0);
    step("n_sr_wr",   1'b1, 16'h0000, 3'b000, B_WR, 3'd3);
    step("n_vec",     1'b1, 16'hC100, 3'b000, B_RD | B_INTACK, 3'd4);

    // irq masked by GIE=0; CMP R4,R5 computes but does not write
    step("f_mask", 1'b1, 16'h9405, 3'b010, B_IF | B_RD, 3'd0);
    step("ex_cmp", 1'b1, 16'h0000, 3'b010, B_EX, 3'd0);

    step("f_jmp",  1'b1, 16'h3C00, 3'b000, B_IF | B_RD, 3'd0);
    step("ex_jmp", 1'b1, 16'h0000, 3'b000, B_NONE, 3'd0);

    step("f_push",   1'b1, 16'h1205, 3'b000, B_IF | B_RD, 3'd0);
    step("push_dec", 1'b1, 16'h0000, 3'b000, B_SPF, 3'd0);
    step("push_wr",  1'b1, 16'h0000, 3'b000, B_WR, 3'd3);

    step("f_reti", 1'b1, 16'h1300, 3'b000, B_IF | B_RD, 3'd0);
    step("pop_sr", 1'b1, 16'h0008, 3'b000, B_RD | B_SRCINC | B_RW, 3'd3);
    step("pop_pc", 1'b1, 16'hC002, 3'b000, B_RD | B_SRCINC | B_RW, 3'd3);

    // illegal word behaves as NOP
    step("f_ill", 1'b1, 16'h0000, 3'b000, B_IF | B_RD, 3'd0);
    chk_state("ill", ST_FETCH);

    // MOV #2,R5 via R3 constant generator: no operand access
    step("f_cg",  1'b1, 16'h4325, 3'b000, B_IF | B_RD, 3'd0);
    step("ex_cg", 1'b1, 16'h0000, 3'b000, B_RW, 3'd0);

    // MOV &abs,R5: R2 with As=01 is absolute and does access memory
    step("f_abs",   1'b1, 16'h4215, 3'b000, B_IF | B_RD, 3'd0);
    step("abs_idx", 1'b1, 16'h0200, 3'b000, B_RD | B_IDXF, 3'd0);
    step("abs_rd",  1'b1, 16'h1111, 3'b000, B_RD, 3'd1);
    step("ex_abs",  1'b1, 16'h0000, 3'b000, B_RW, 3'd0);

    // RRC @R5, then reset while the write-back is stalled
    step("f_rrc",     1'b1, 16'h1025, 3'b000, B_IF | B_RD, 3'd0);
    step("src_ind",   1'b1, 16'h00FF, 3'b000, B_RD, 3'd1);
    step("ex_rrc",    1'b1, 16'h0000, 3'b000, B_EX, 3'd0);
    step("wb_rrc",    1'b0, 16'h0000, 3'b000, B_WR, 3'd2);
    rst = 1'b0;
    #1;
    chk("midrst.strb", strb_now, 16'h0000);
    chk("midrst.mab", {13'b0, mab_sel}, 16'd4);
    chk("midrst.iw", IW, 16'h0000);
    chk_state("midrst", ST_RESET_VEC);
    #1 rst = 1'b1;

    step("rv2",     1'b1, 16'h4400, 3'b000, B_RD | B_INTACK, 3'd4);
    step("f_after", 1'b1, 16'h5405, 3'b000, B_IF | B_RD, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
